// File: rtl/sm3_pkg.sv
// Shared SM3 definitions for the permutation datapath.
// - sm3_mode_e : per-beat permutation select (P0 for the compression path, P1 for expansion)
// - SM3_P*_ROT_* : rotation amounts of the two linear permutations
// - rol : left-circular rotate of a word of width w (w <= SM3_MAX_W), amount taken modulo w
package sm3_pkg;

   typedef enum logic {
      SM3_P0 = 1'b0,
      SM3_P1 = 1'b1
   } sm3_mode_e;

   localparam int unsigned SM3_P0_ROT_A = 9;
   localparam int unsigned SM3_P0_ROT_B = 17;
   localparam int unsigned SM3_P1_ROT_A = 15;
   localparam int unsigned SM3_P1_ROT_B = 23;

   // Widest word rol can handle; narrower words ride in the low bits.
   localparam int unsigned SM3_MAX_W = 64;
   localparam int unsigned SM3_IDX_W = 6;

   typedef logic [SM3_MAX_W-1:0] sm3_word_t;

   // Bit i of the result comes from bit (i - n) mod w; bits at or above w are zero.
   function automatic sm3_word_t rol(input sm3_word_t x, input int unsigned n,
                                     input int unsigned w);
      sm3_word_t   r;
      int unsigned s;
      r = '0;
      s = n % w;
      for (int unsigned i = 0; i < SM3_MAX_W; i++) begin
         if (i < w) begin
            r[SM3_IDX_W'(i)] = x[SM3_IDX_W'((i + w - s) % w)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sm3_perm_pipe_if.sv
// Stream interface of the SM3 permutation pipe.
// - in_*  : producer side (valid/ready, mode, LANES*WORD_W data, tag)
// - out_* : consumer side (valid/ready, data, tag)
// - beat_cnt : completed output transfers
// Modports: master = producer/consumer environment, slave = the pipe.
interface sm3_perm_pipe_if
   import sm3_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned LANES  = 1,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned CNT_W  = 16
);

   logic                      in_valid;
   logic                      in_ready;
   sm3_mode_e                 in_mode;
   logic [LANES*WORD_W-1:0]   in_data;
   logic [TAG_W-1:0]          in_tag;
   logic                      out_valid;
   logic                      out_ready;
   logic [LANES*WORD_W-1:0]   out_data;
   logic [TAG_W-1:0]          out_tag;
   logic [CNT_W-1:0]          beat_cnt;

   modport master (
      output in_valid, in_mode, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, beat_cnt
   );

   modport slave (
      input  in_valid, in_mode, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, beat_cnt
   );

endinterface

// File: rtl/sm3_perm_lane.sv
// One lane of the SM3 linear permutation, purely combinational.
// - x, mode : input word and permutation select
// - t, u    : first-stage terms, t = x ^ rol(x,A), u = rol(x,B)
// - t_s, u_s: the same terms after the pipe has (optionally) registered them
// - y       : final result t_s ^ u_s
module sm3_perm_lane
   import sm3_pkg::*;
#(
   parameter int unsigned WORD_W = 32
) (
   input  logic [WORD_W-1:0] x,
   input  sm3_mode_e         mode,
   output logic [WORD_W-1:0] t,
   output logic [WORD_W-1:0] u,
   input  logic [WORD_W-1:0] t_s,
   input  logic [WORD_W-1:0] u_s,
   output logic [WORD_W-1:0] y
);

   if (WORD_W == 0 || WORD_W > SM3_MAX_W) begin : g_bad_width
      $error("sm3_perm_lane: WORD_W out of range");
   end

   sm3_word_t x_w;

   // Constant rotations on both paths then a 2:1 mux: pure wiring plus XOR.
   always_comb begin
      x_w = sm3_word_t'(x);
      if (mode == SM3_P1) begin
         t = x ^ WORD_W'(rol(x_w, SM3_P1_ROT_A, WORD_W));
         u = WORD_W'(rol(x_w, SM3_P1_ROT_B, WORD_W));
      end else begin
         t = x ^ WORD_W'(rol(x_w, SM3_P0_ROT_A, WORD_W));
         u = WORD_W'(rol(x_w, SM3_P0_ROT_B, WORD_W));
      end
   end

   assign y = t_s ^ u_s;

endmodule

// File: rtl/sm3_perm_pipe.sv
// Pipelined multi-lane SM3 permutation: out = x ^ rol(x,A) ^ rol(x,B) per lane.
// - clk, rst : rising-edge clock, synchronous active-high reset
// - bus      : sm3_perm_pipe_if slave (in_* stream, out_* stream, beat_cnt)
// STAGES = 2 registers (t,u) then t^u; STAGES = 1 registers the full result.
// Each stage is ready when empty or when the stage after it drains, so in_ready
// is combinational from out_ready and bubbles collapse.
module sm3_perm_pipe
   import sm3_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned LANES  = 1,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned CNT_W  = 16
) (
   input logic            clk,
   input logic            rst,
   sm3_perm_pipe_if.slave bus
);

   localparam int unsigned DATA_W = LANES * WORD_W;

   logic [DATA_W-1:0] t_c, u_c, t_s, u_s, y_c;
   logic              mid_valid;
   logic [TAG_W-1:0]  mid_tag;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [TAG_W-1:0]  out_tag_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              out_stage_ready;

   assign out_stage_ready = ~out_valid_q | bus.out_ready;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sm3_perm_lane #(
         .WORD_W (WORD_W)
      ) u_lane (
         .x    (bus.in_data[i*WORD_W +: WORD_W]),
         .mode (bus.in_mode),
         .t    (t_c[i*WORD_W +: WORD_W]),
         .u    (u_c[i*WORD_W +: WORD_W]),
         .t_s  (t_s[i*WORD_W +: WORD_W]),
         .u_s  (u_s[i*WORD_W +: WORD_W]),
         .y    (y_c[i*WORD_W +: WORD_W])
      );
   end

   if (STAGES == 2) begin : g_two
      logic              s1_valid_q;
      logic [DATA_W-1:0] s1_t_q, s1_u_q;
      logic [TAG_W-1:0]  s1_tag_q;
      logic              s1_ready;

      assign s1_ready     = ~s1_valid_q | out_stage_ready;
      assign bus.in_ready = s1_ready;

      // Mode is folded into t/u here, so it need not travel further.
      always_ff @(posedge clk) begin
         if (rst) begin
            s1_valid_q <= 1'b0;
            s1_t_q     <= '0;
            s1_u_q     <= '0;
            s1_tag_q   <= '0;
         end else if (s1_ready) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
               s1_t_q   <= t_c;
               s1_u_q   <= u_c;
               s1_tag_q <= bus.in_tag;
            end
         end
      end

      assign t_s       = s1_t_q;
      assign u_s       = s1_u_q;
      assign mid_valid = s1_valid_q;
      assign mid_tag   = s1_tag_q;
   end else if (STAGES == 1) begin : g_one
      assign bus.in_ready = out_stage_ready;
      assign t_s          = t_c;
      assign u_s          = u_c;
      assign mid_valid    = bus.in_valid;
      assign mid_tag      = bus.in_tag;
   end else begin : g_bad_stages
      $error("sm3_perm_pipe: STAGES must be 1 or 2");
   end

   // Output stage: the only source of out_*, so no in_* to out_* combinational path.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
      end else if (out_stage_ready) begin
         out_valid_q <= mid_valid;
         if (mid_valid) begin
            out_data_q <= y_c;
            out_tag_q  <= mid_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (out_valid_q && bus.out_ready) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_tag   = out_tag_q;
   assign bus.beat_cnt  = cnt_q;

endmodule

// File: tb/tb_sm3_perm_pipe.sv
// Bench for sm3_perm_pipe: a 2-stage and a 1-stage instance (LANES=4, CNT_W=4) share one
// stimulus set; sel picks whose outputs the tests observe, lat is that instance's latency.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_sm3_perm_pipe;
   import sm3_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned L  = 4;
   localparam int unsigned TW = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned DW = W * L;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [TW-1:0] tag;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic      sel;
   int        lat;
   int        n_tests = 0;
   int        n_fail  = 0;

   logic          in_valid;
   sm3_mode_e     in_mode;
   logic [DW-1:0] in_data;
   logic [TW-1:0] in_tag;
   logic          out_ready;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [TW-1:0] out_tag;
   logic [CW-1:0] beat_cnt;

   sm3_perm_pipe_if #(.WORD_W(W), .LANES(L), .TAG_W(TW), .CNT_W(CW)) ifa ();
   sm3_perm_pipe_if #(.WORD_W(W), .LANES(L), .TAG_W(TW), .CNT_W(CW)) ifb ();

   assign ifa.in_valid  = in_valid;
   assign ifa.in_mode   = in_mode;
   assign ifa.in_data   = in_data;
   assign ifa.in_tag    = in_tag;
   assign ifa.out_ready = out_ready;
   assign ifb.in_valid  = in_valid;
   assign ifb.in_mode   = in_mode;
   assign ifb.in_data   = in_data;
   assign ifb.in_tag    = in_tag;
   assign ifb.out_ready = out_ready;

   assign in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
   assign out_valid = sel ? ifb.out_valid : ifa.out_valid;
   assign out_data  = sel ? ifb.out_data  : ifa.out_data;
   assign out_tag   = sel ? ifb.out_tag   : ifa.out_tag;
   assign beat_cnt  = sel ? ifb.beat_cnt  : ifa.beat_cnt;

   sm3_perm_pipe #(
      .WORD_W (W), .LANES (L), .STAGES (2), .TAG_W (TW), .CNT_W (CW)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   sm3_perm_pipe #(
      .WORD_W (W), .LANES (L), .STAGES (1), .TAG_W (TW), .CNT_W (CW)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   // Reference: rol via the high half of a doubled word shifted left.
   function automatic logic [W-1:0] rol_m(input logic [W-1:0] x, input int n);
      logic [2*W-1:0] d;
      d = {x, x} << n;
      return d[2*W-1 -: W];
   endfunction

   function automatic logic [W-1:0] perm_m(input logic [W-1:0] x, input sm3_mode_e m);
      if (m == SM3_P1) return x ^ rol_m(x, 15) ^ rol_m(x, 23);
      return x ^ rol_m(x, 9) ^ rol_m(x, 17);
   endfunction

   function automatic logic [DW-1:0] beat_m(input logic [DW-1:0] d, input sm3_mode_e m);
      logic [DW-1:0] r;
      for (int i = 0; i < L; i++) r[i*W +: W] = perm_m(d[i*W +: W], m);
      return r;
   endfunction

   task automatic do_reset;
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_mode   = SM3_P0;
      in_data   = '0;
      in_tag    = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid S%0d: got %b want 0", lat, out_valid);
      end
      n_tests++;
      if (out_data !== '0) begin
         n_fail++; $display("FAIL reset_out_data S%0d: got %h want 0", lat, out_data);
      end
      n_tests++;
      if (out_tag !== '0) begin
         n_fail++; $display("FAIL reset_out_tag S%0d: got %h want 0", lat, out_tag);
      end
      n_tests++;
      if (beat_cnt !== '0) begin
         n_fail++; $display("FAIL reset_beat_cnt S%0d: got %0d want 0", lat, beat_cnt);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready S%0d: got %b want 1", lat, in_ready);
      end
   endtask

   // Hand-computed vectors: lanes {FFFFFFFF, 0, 80000000, 00000001}.
   task automatic test_vectors;
      logic [DW-1:0] din;
      logic [DW-1:0] exp_d [2];
      sm3_mode_e     md    [2];
      din      = {32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h00000001};
      md[0]    = SM3_P0;
      exp_d[0] = {32'hFFFFFFFF, 32'h00000000, 32'h80010100, 32'h00020201};
      md[1]    = SM3_P1;
      exp_d[1] = {32'hFFFFFFFF, 32'h00000000, 32'h80404000, 32'h00808001};
      for (int k = 0; k < 2; k++) begin
         do_reset;
         @(negedge clk);
         in_valid  = 1'b1;
         in_mode   = md[k];
         in_data   = din;
         in_tag    = TW'(5 + k);
         out_ready = 1'b1;
         #1;
         n_tests++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL vec_pre S%0d: got ready=%b valid=%b want 1 0", lat, in_ready, out_valid);
         end
         @(negedge clk);
         in_valid = 1'b0;
         repeat (lat - 1) @(negedge clk);
         #1;
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_tag !== TW'(5 + k)) begin
            n_fail++;
            $display("FAIL vec_result S%0d m%0d: got v=%b %h t=%h want v=1 %h t=%h", lat, k,
                     out_valid, out_data, out_tag, exp_d[k], TW'(5 + k));
         end
         @(negedge clk);
         #1;
         n_tests++;
         if (out_valid !== 1'b0 || beat_cnt !== CW'(1)) begin
            n_fail++;
            $display("FAIL vec_after S%0d: got v=%b cnt=%0d want v=0 cnt=1", lat, out_valid,
                     beat_cnt);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] d   [3];
      sm3_mode_e     md  [3];
      md[0] = SM3_P0; md[1] = SM3_P1; md[2] = SM3_P0;
      for (int j = 0; j < 3; j++) d[j] = {32'h80000000, 32'hDEADBEEF, 32'h12345678, 32'(j + 1)};
      do_reset;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < lat + 4; cyc++) begin
         @(negedge clk);
         if (cyc < 3) begin
            in_valid = 1'b1; in_mode = md[cyc]; in_data = d[cyc]; in_tag = TW'(cyc + 1);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc >= lat && cyc < lat + 3) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== beat_m(d[cyc-lat], md[cyc-lat]) ||
                out_tag !== TW'(cyc - lat + 1)) begin
               n_fail++;
               $display("FAIL b2b_beat%0d S%0d: got v=%b %h t=%h want v=1 %h t=%h", cyc - lat,
                        lat, out_valid, out_data, out_tag,
                        beat_m(d[cyc-lat], md[cyc-lat]), TW'(cyc - lat + 1));
            end
         end else begin
            n_tests++;
            if (out_valid !== 1'b0) begin
               n_fail++; $display("FAIL b2b_idle c%0d S%0d: got v=%b want 0", cyc, lat, out_valid);
            end
         end
      end
   endtask

   task automatic test_stall;
      beat_t         q [$];
      beat_t         e;
      int            sent = 0;
      int            rcvd = 0;
      bit            took = 1'b0;
      logic [W-1:0]  w;
      do_reset;
      for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
         @(negedge clk);
         if (took) begin in_valid = 1'b0; took = 1'b0; end
         if (!in_valid && sent < 8) begin
            w        = 32'h9E3779B9 * 32'(sent + 1);
            in_valid = 1'b1;
            in_mode  = sm3_mode_e'(sent % 2);
            in_data  = {w, ~w, w ^ 32'h5A5A5A5A, 32'(sent)};
            in_tag   = TW'(sent + 3);
         end
         out_ready = (cyc >= 5);
         #1;
         if (cyc < 5) begin
            n_tests++;
            if (in_ready !== 1'(cyc < lat)) begin
               n_fail++;
               $display("FAIL stall_in_ready c%0d S%0d: got %b want %b", cyc, lat, in_ready,
                        1'(cyc < lat));
            end
         end
         if (out_valid && out_ready) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL stall_extra S%0d: got tag %h want none", lat, out_tag);
            end else begin
               e = q.pop_front();
               if (out_data !== e.data || out_tag !== e.tag) begin
                  n_fail++;
                  $display("FAIL stall_order S%0d: got %h t=%h want %h t=%h", lat, out_data,
                           out_tag, e.data, e.tag);
               end
            end
            rcvd++;
         end
         if (in_valid && in_ready) begin
            e.data = beat_m(in_data, in_mode);
            e.tag  = in_tag;
            q.push_back(e);
            sent++;
            took = 1'b1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_tests++;
      if (rcvd != 8 || q.size() != 0 || out_valid !== 1'b0 || beat_cnt !== CW'(8)) begin
         n_fail++;
         $display("FAIL stall_totals S%0d: got rcvd=%0d left=%0d v=%b cnt=%0d want 8 0 0 8",
                  lat, rcvd, q.size(), out_valid, beat_cnt);
      end
   endtask

   task automatic test_reset_midflight;
      logic [DW-1:0] d;
      d = {32'h0000FFFF, 32'hA5A5A5A5, 32'h00000001, 32'h80000000};
      do_reset;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_mode = SM3_P0; in_data = d; in_tag = TW'(7);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (lat) @(negedge clk);
      #1;
      n_tests++;
      if (beat_cnt !== CW'(1)) begin
         n_fail++; $display("FAIL mid_pre_cnt S%0d: got %0d want 1", lat, beat_cnt);
      end
      // Stall the consumer and push two beats, then reset while they are held.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = SM3_P1; in_data = ~d; in_tag = TW'(1);
      @(negedge clk);
      in_tag = TW'(2); in_data = d ^ {4{32'h11111111}};
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || beat_cnt !== '0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_after_rst S%0d: got v=%b cnt=%0d rdy=%b want 0 0 1", lat, out_valid,
                  beat_cnt, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b1; in_mode = SM3_P1; in_data = d; in_tag = TW'(9);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (lat - 1) @(negedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== beat_m(d, SM3_P1) || out_tag !== TW'(9)) begin
         n_fail++;
         $display("FAIL mid_post_beat S%0d: got v=%b %h t=%h want v=1 %h t=9", lat, out_valid,
                  out_data, out_tag, beat_m(d, SM3_P1));
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || beat_cnt !== CW'(1)) begin
         n_fail++;
         $display("FAIL mid_drain S%0d: got v=%b cnt=%0d want 0 1", lat, out_valid, beat_cnt);
      end
   endtask

   task automatic test_wrap;
      do_reset;
      out_ready = 1'b1;
      for (int j = 0; j < 17; j++) begin
         @(negedge clk);
         in_valid = 1'b1; in_mode = sm3_mode_e'(j % 2); in_data = {4{32'(j)}}; in_tag = TW'(j);
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (lat + 1) @(negedge clk);
      #1;
      n_tests++;
      if (beat_cnt !== CW'(1)) begin
         n_fail++; $display("FAIL wrap_cnt S%0d: got %0d want 1", lat, beat_cnt);
      end
   endtask

   task automatic test_random(input int n);
      beat_t q [$];
      beat_t e;
      int    sent = 0;
      int    rcvd = 0;
      int    cyc  = 0;
      bit    took = 1'b0;
      do_reset;
      while ((sent < n || rcvd < n) && cyc < 20 * n) begin
         @(negedge clk);
         cyc++;
         if (took) begin in_valid = 1'b0; took = 1'b0; end
         if (!in_valid && sent < n && $urandom_range(3) != 0) begin
            in_valid = 1'b1;
            in_mode  = sm3_mode_e'($urandom_range(1));
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_tag   = TW'(sent);
         end
         out_ready = ($urandom_range(3) != 0);
         #1;
         if (out_valid && out_ready) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL rand_extra S%0d: got tag %h want none", lat, out_tag);
            end else begin
               e = q.pop_front();
               if (out_data !== e.data || out_tag !== e.tag) begin
                  n_fail++;
                  $display("FAIL rand_beat S%0d: got %h t=%h want %h t=%h", lat, out_data,
                           out_tag, e.data, e.tag);
               end
            end
            rcvd++;
         end
         if (in_valid && in_ready) begin
            e.data = beat_m(in_data, in_mode);
            e.tag  = in_tag;
            q.push_back(e);
            sent++;
            took = 1'b1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_tests++;
      if (rcvd != n || beat_cnt !== CW'(n)) begin
         n_fail++;
         $display("FAIL rand_totals S%0d: got rcvd=%0d cnt=%0d want %0d %0d", lat, rcvd,
                  beat_cnt, n, CW'(n));
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      in_mode   = SM3_P0;
      in_data   = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      sel       = 1'b0;
      lat       = 2;
      for (int p = 0; p < 2; p++) begin
         sel = p[0];
         lat = (p == 0) ? 2 : 1;
         test_reset;
         test_vectors;
         test_back_to_back;
         test_stall;
         test_reset_midflight;
         test_wrap;
         test_random(300);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
